// File: rtl/odd_stream_monitor.sv
// Odd-counter stream monitor: tracks a +2 odd sequence,
// reports lock, errors and sample statistics.
module odd_stream_monitor #(
  parameter int LOCK_LEN = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_valid,
  input  logic [7:0]       din,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [15:0]      sample_cnt,
  output logic [7:0]       last_val
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_LEN);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] match;
  logic [3:0] match_nxt;
  logic [3:0] match_inc;
  logic [7:0] expected;
  logic [7:0] expected_nxt;
  logic       err;
  logic       accept;
  logic       odd;
  logic       hit;

  assign accept    = din_valid & ~clr;
  assign odd       = din[0];
  assign hit       = (din == expected);
  assign match_inc = match + 4'd1;

  // state, match counter and expected value registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      match    <= '0;
      expected <= '0;
    end else if (clr) begin
      state    <= IDLE;
      match    <= '0;
      expected <= '0;
    end else begin
      state    <= state_nxt;
      match    <= match_nxt;
      expected <= expected_nxt;
    end
  end

  // sequence tracking: next state and error detection
  always_comb begin
    state_nxt    = state;
    match_nxt    = match;
    expected_nxt = expected;
    err          = 1'b0;
    if (accept) begin
      expected_nxt = din + 8'd2;
      match_nxt    = '0;
      unique case (state)
        IDLE: begin
          if (odd) state_nxt = ACQ;
          else     err       = 1'b1;
        end
        ACQ: begin
          if (hit) begin
            match_nxt = match_inc;
            if (match_inc == LOCK_N)
              state_nxt = LOCK;
          end else if (!odd) begin
            state_nxt = IDLE;
            err       = 1'b1;
          end
        end
        LOCK: begin
          if (hit) begin
            match_nxt = match;
          end else if (odd) begin
            state_nxt = ACQ;
            err       = 1'b1;
          end else begin
            state_nxt = IDLE;
            err       = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // lock indication decoded from the state register
  always_comb begin
    locked = (state == LOCK);
  end

  // registered error pulse and statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_pulse  <= 1'b0;
      err_cnt    <= '0;
      sample_cnt <= '0;
      last_val   <= '0;
    end else if (clr) begin
      err_pulse  <= 1'b0;
      err_cnt    <= '0;
      sample_cnt <= '0;
      last_val   <= '0;
    end else begin
      err_pulse <= err;
      if (err && (err_cnt != '1))
        err_cnt <= err_cnt + ERR_W'(1);
      if (accept) begin
        sample_cnt <= sample_cnt + 16'd1;
        last_val   <= din;
      end
    end
  end

endmodule

// File: tb/tb_odd_stream_monitor.sv
// Directed bench for odd_stream_monitor: vector table
// plus hand-written multi-cycle sequences.
module tb_odd_stream_monitor;

  logic        clk;
  logic        reset;
  logic        din_valid;
  logic [7:0]  din;
  logic        clr;
  logic        locked;
  logic        err_pulse;
  logic [7:0]  err_cnt;
  logic [15:0] sample_cnt;
  logic [7:0]  last_val;

  logic        l1;
  logic        ep1;
  logic [7:0]  ec1;
  logic [15:0] sc1;
  logic [7:0]  lv1;

  int tests = 0;
  int fails = 0;

  odd_stream_monitor #(.LOCK_LEN(2), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .din_valid(din_valid),
    .din(din), .clr(clr), .locked(locked),
    .err_pulse(err_pulse), .err_cnt(err_cnt),
    .sample_cnt(sample_cnt), .last_val(last_val)
  );

  odd_stream_monitor #(.LOCK_LEN(1), .ERR_W(8)) dut1 (
    .clk(clk), .reset(reset), .din_valid(din_valid),
    .din(din), .clr(clr), .locked(l1),
    .err_pulse(ep1), .err_cnt(ec1),
    .sample_cnt(sc1), .last_val(lv1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        c;
    logic [7:0]  d;
    logic        lk;
    logic        ep;
    logic [7:0]  ec;
    logic [15:0] sc;
    logic [7:0]  lv;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(
    logic v, logic c, logic [7:0] d, logic lk,
    logic ep, logic [7:0] ec, logic [15:0] sc,
    logic [7:0] lv);
    vec_t r;
    r.v = v; r.c = c; r.d = d; r.lk = lk;
    r.ep = ep; r.ec = ec; r.sc = sc; r.lv = lv;
    return r;
  endfunction

  function automatic logic [33:0] pk(
    logic lk, logic ep, logic [7:0] ec,
    logic [15:0] sc, logic [7:0] lv);
    return {lk, ep, ec, sc, lv};
  endfunction

  function automatic logic [33:0] outs();
    return {locked, err_pulse, err_cnt, sample_cnt, last_val};
  endfunction

  task automatic chk(input string nm,
                     input logic [33:0] got,
                     input logic [33:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic c,
                     input logic [7:0] d);
    din_valid = v;
    clr       = c;
    din       = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 8'd1,   0, 0, 0, 1,  8'd1);
    tbl[1]  = mk(1, 0, 8'd3,   0, 0, 0, 2,  8'd3);
    tbl[2]  = mk(1, 0, 8'd5,   1, 0, 0, 3,  8'd5);
    tbl[3]  = mk(1, 0, 8'd7,   1, 0, 0, 4,  8'd7);
    tbl[4]  = mk(0, 0, 8'd99,  1, 0, 0, 4,  8'd7);
    tbl[5]  = mk(1, 0, 8'd13,  0, 1, 1, 5,  8'd13);
    tbl[6]  = mk(0, 0, 8'd0,   0, 0, 1, 5,  8'd13);
    tbl[7]  = mk(1, 0, 8'd15,  0, 0, 1, 6,  8'd15);
    tbl[8]  = mk(1, 0, 8'd17,  1, 0, 1, 7,  8'd17);
    tbl[9]  = mk(1, 0, 8'd19,  1, 0, 1, 8,  8'd19);
    tbl[10] = mk(1, 0, 8'd20,  0, 1, 2, 9,  8'd20);
    tbl[11] = mk(1, 0, 8'd4,   0, 1, 3, 10, 8'd4);
    tbl[12] = mk(1, 0, 8'd251, 0, 0, 3, 11, 8'd251);
    tbl[13] = mk(1, 0, 8'd253, 0, 0, 3, 12, 8'd253);
    tbl[14] = mk(1, 0, 8'd255, 1, 0, 3, 13, 8'd255);
    tbl[15] = mk(1, 0, 8'd1,   1, 0, 3, 14, 8'd1);
    tbl[16] = mk(1, 0, 8'd3,   1, 0, 3, 15, 8'd3);
    tbl[17] = mk(1, 0, 8'd7,   0, 1, 4, 16, 8'd7);
    tbl[18] = mk(1, 0, 8'd11,  0, 0, 4, 17, 8'd11);
    tbl[19] = mk(1, 0, 8'd13,  0, 0, 4, 18, 8'd13);
    tbl[20] = mk(1, 0, 8'd15,  1, 0, 4, 19, 8'd15);
    tbl[21] = mk(1, 1, 8'd17,  0, 0, 0, 0,  8'd0);
    tbl[22] = mk(1, 0, 8'd17,  0, 0, 0, 1,  8'd17);
    tbl[23] = mk(0, 1, 8'd0,   0, 0, 0, 0,  8'd0);

    reset     = 1'b0;
    din_valid = 1'b0;
    clr       = 1'b0;
    din       = 8'd0;
    #1;
    chk("reset_t0", outs(), '0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", outs(), '0);
    reset = 1'b1;

    for (int i = 0; i < 24; i++) begin
      cyc(tbl[i].v, tbl[i].c, tbl[i].d);
      chk($sformatf("vec%0d", i), outs(),
          pk(tbl[i].lk, tbl[i].ep, tbl[i].ec,
             tbl[i].sc, tbl[i].lv));
    end

    // three errors then lock, async reset mid-cycle
    cyc(1, 0, 8'd2);
    cyc(1, 0, 8'd2);
    cyc(1, 0, 8'd2);
    cyc(1, 0, 8'd1);
    cyc(1, 0, 8'd3);
    cyc(1, 0, 8'd5);
    chk("pre_async", outs(), pk(1, 0, 3, 6, 8'd5));
    cyc(0, 0, 8'd0);
    #3;
    reset = 1'b0;
    #1;
    chk("async_rst", outs(), '0);
    din_valid = 1'b1;
    din       = 8'd9;
    @(posedge clk);
    #1;
    chk("no_accept_in_rst", outs(), '0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_idle", outs(), pk(0, 0, 0, 1, 8'd9));
    cyc(1, 0, 8'd11);
    cyc(1, 0, 8'd13);
    chk("post_rst_lock", outs(), pk(1, 0, 0, 3, 8'd13));

    // reset during an error pulse
    cyc(1, 0, 8'd6);
    chk("even_in_lock", outs(), pk(0, 1, 1, 4, 8'd6));
    din_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("rst_in_pulse", outs(), '0);
    #1;
    reset = 1'b1;

    // gapped stream locks like back-to-back
    cyc(1, 0, 8'd1);
    chk("l1_after_1", {33'd0, l1}, 34'd0);
    repeat (3) cyc(0, 0, 8'd0);
    chk("gap_no_lock", outs(), pk(0, 0, 0, 1, 8'd1));
    cyc(1, 0, 8'd3);
    chk("l1_after_3", {33'd0, l1}, 34'd1);
    chk("gap_acq", outs(), pk(0, 0, 0, 2, 8'd3));
    repeat (3) cyc(0, 0, 8'd0);
    cyc(1, 0, 8'd5);
    chk("gap_lock", outs(), pk(1, 0, 0, 3, 8'd5));

    // error counter saturation
    cyc(0, 1, 8'd0);
    for (int k = 0; k < 300; k++) cyc(1, 0, 8'd4);
    chk("err_sat", outs(), pk(0, 1, 8'd255, 16'd300, 8'd4));
    cyc(0, 0, 8'd0);
    chk("err_sat_hold", outs(), pk(0, 0, 8'd255, 16'd300, 8'd4));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
